fp_norm_round: RTL

- Downstream stage of addsub_block in the FPU add/sub datapath.
- Consumes the raw 24-bit mantissa sum and carry, the aligned exponent, the sign, and the guard/round/sticky bits from the aligner.
- Normalizes iteratively (one shift per cycle), rounds to nearest-even, and emits a packed IEEE-754 single-precision result with flags.
- Uses valid/ready handshakes on both sides.

---
 rtl/fp_norm_round_if.sv | 28 ++
 rtl/fp_norm_round.sv | 136 +++++++++++++
 2 files changed

// File: rtl/fp_norm_round_if.sv
// Handshake and data bundle between addsub_block and fp_norm_round.
interface fp_norm_round_if #(
   parameter int MANT_W = 24,
   parameter int EXP_W  = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [MANT_W-1:0] sum_in;
   logic              c_out_in;
   logic [EXP_W-1:0]  exp_in;
   logic              sign_in;
   logic [2:0]        grs_in;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       result;
   logic              overflow;
   logic              zero;

   modport master (
      output in_valid, sum_in, c_out_in, exp_in, sign_in, grs_in, out_ready,
      input  in_ready, out_valid, result, overflow, zero
   );

   modport slave (
      input  in_valid, sum_in, c_out_in, exp_in, sign_in, grs_in, out_ready,
      output in_ready, out_valid, result, overflow, zero
   );
endinterface

// File: rtl/fp_norm_round.sv
// Iterative normaliser and round-to-nearest-even stage for the FPU add/sub
// path; packs an IEEE-754 single-precision result with overflow/zero flags.
module fp_norm_round #(
   parameter int MANT_W = 24,
   parameter int EXP_W  = 8,
   parameter int BIAS   = 127
) (
   input logic             clk,
   input logic             rst,
   fp_norm_round_if.slave  bus
);
   localparam int MW = MANT_W + 4;   // {carry, sum, g, r, s}
   localparam int HB = MANT_W + 2;   // hidden-bit position
   localparam int EW = EXP_W + 2;    // signed working exponent

   localparam logic signed [EW-1:0] E_ONE = EW'(1);
   localparam logic signed [EW-1:0] E_INF = EW'(2 * BIAS + 1);

   typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

   state_t                  state;
   logic [MW-1:0]           m;
   logic signed [EW-1:0]    e;
   logic                    sign;

   logic [MW-1:0]           m_ld;
   logic signed [EW-1:0]    e_ld;
   logic [MW-1:0]           m_n;
   logic signed [EW-1:0]    e_n;
   logic                    rnd_up;
   logic [MANT_W:0]         inc;
   logic [MANT_W-1:0]       mant;
   logic signed [EW-1:0]    e_r;
   logic                    ovf_r;
   logic [31:0]             res_r;

   function automatic logic needs_shift(input logic [MW-1:0] mv,
                                        input logic signed [EW-1:0] ev);
      return mv[MW-1] | (~mv[HB] & (ev > E_ONE));
   endfunction

   assign m_ld = {bus.c_out_in, bus.sum_in, bus.grs_in};
   assign e_ld = {{(EW-EXP_W){1'b0}}, bus.exp_in};

   // One normalisation step: right shift keeping sticky, else left shift while exponent allows.
   always_comb begin
      m_n = m;
      e_n = e;
      if (m[MW-1]) begin
         m_n = {1'b0, m[MW-1:2], m[1] | m[0]};
         e_n = e + E_ONE;
      end else if (!m[HB] && (e > E_ONE)) begin
         m_n = m << 1;
         e_n = e - E_ONE;
      end
   end

   // Round to nearest even, renormalise a rounding carry, then pack or saturate.
   always_comb begin
      rnd_up = m[2] & (m[1] | m[0] | m[3]);
      inc    = {1'b0, m[HB:3]} + {{MANT_W{1'b0}}, rnd_up};
      if (inc[MANT_W]) begin
         mant = inc[MANT_W:1];
         e_r  = e + E_ONE;
      end else begin
         mant = inc[MANT_W-1:0];
         e_r  = e;
      end
      ovf_r = (e_r >= E_INF);
      if (ovf_r)
         res_r = {sign, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
      else
         res_r = {sign, (mant[MANT_W-1] ? e_r[EXP_W-1:0] : {EXP_W{1'b0}}),
                  mant[MANT_W-2:0]};
   end

   // Control FSM with registered handshake outputs and result.
   // The next-state test looks at the post-step mantissa, so the cycle that
   // completes normalisation (or an accept needing none) goes straight to ROUND.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.result    <= '0;
         bus.overflow  <= 1'b0;
         bus.zero      <= 1'b0;
         m             <= '0;
         e             <= '0;
         sign          <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid && bus.in_ready) begin
                  m            <= m_ld;
                  e            <= e_ld;
                  sign         <= bus.sign_in;
                  bus.overflow <= 1'b0;
                  bus.zero     <= 1'b0;
                  bus.in_ready <= 1'b0;
                  if (m_ld == '0) begin
                     bus.result    <= '0;
                     bus.zero      <= 1'b1;
                     bus.out_valid <= 1'b1;
                     state         <= DONE;
                  end else if (needs_shift(m_ld, e_ld)) begin
                     state <= NORM;
                  end else begin
                     state <= ROUND;
                  end
               end
            end
            NORM: begin
               m <= m_n;
               e <= e_n;
               if (!needs_shift(m_n, e_n))
                  state <= ROUND;
            end
            ROUND: begin
               bus.result    <= res_r;
               bus.overflow  <= ovf_r;
               bus.out_valid <= 1'b1;
               state         <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
